// File: rtl/spi_master.sv
// Mode-3 SPI initiator: byte stream in, received bytes out as one-cycle strobes, multi-byte frames with cs held low.
// Build option: SPI_MASTER_LOOPBACK_EN samples the internal mosi register instead of miso (board self-test).
//
// state  | meaning
// IDLE   | cs high, waiting for the first byte of a frame
// LEAD   | cs low, sclk high, lead time before the first sclk fall
// LOW    | sclk low half-period, mosi presents the current bit
// HIGH   | sclk high half-period, miso sampled on its last cycle
// WAIT   | between bytes of a frame, cs low and sclk high, waiting for the next byte
// LAG    | cs still low after the final byte
// GAP    | cs high, minimum idle time before the next frame
module spi_master #(
  parameter int CLK_DIV = 14,
  parameter int CS_LEAD = 4,
  parameter int CS_LAG  = 4,
  parameter int CS_IDLE = 8
) (
  input  logic       clk27m,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_LOW,
    S_HIGH,
    S_WAIT,
    S_LAG,
    S_GAP
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic [2:0] bit_q;
  logic       last_q;
  logic       pend_q;
  logic [7:0] tx_sh_q;
  logic [7:0] rx_sh_q;
  logic       rx_bit;
  logic       tc;
  logic       hs;
  logic       enter;
  logic       sclk_d;
  logic       cs_d;
  logic       busy_d;

  assign tc    = (cnt_q == 8'd0);
  assign hs    = tx_valid & tx_ready;
  assign enter = (state_d != state_q);

  function automatic logic [7:0] period(input state_t s);
    case (s)
      S_LEAD:         period = 8'(CS_LEAD - 1);
      S_LOW, S_HIGH:  period = 8'(CLK_DIV - 1);
      S_LAG:          period = 8'(CS_LAG - 1);
      S_GAP:          period = 8'(CS_IDLE - 1);
      default:        period = 8'd0;
    endcase
  endfunction

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_bit      = mosi;
`else
  logic miso_s1;
  logic miso_s2;

  always_ff @(posedge clk27m or posedge rst) begin
    if (rst) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= miso;
      miso_s2 <= miso_s1;
    end
  end

  assign rx_bit = miso_s2;
`endif

  always_ff @(posedge clk27m or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (hs) state_d = S_LEAD;
      S_LEAD: if (tc) state_d = S_LOW;
      S_LOW:  if (tc) state_d = S_HIGH;
      S_HIGH: begin
        if (tc) begin
          if (bit_q != 3'd0) state_d = S_LOW;
          else if (last_q)   state_d = S_LAG;
          else               state_d = S_WAIT;
        end
      end
      // a byte accepted in WAIT spends one more cycle here (pend_q) before the first fall
      S_WAIT: if (pend_q) state_d = S_LOW;
      S_LAG:  if (tc) state_d = S_GAP;
      S_GAP:  if (tc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state_q == S_IDLE) || ((state_q == S_WAIT) && !pend_q);
    sclk_d   = (state_d != S_LOW);
    busy_d   = (state_d != S_IDLE);
    cs_d     = 1'b1;
    case (state_d)
      S_LEAD, S_LOW, S_HIGH, S_WAIT, S_LAG: cs_d = 1'b0;
      default:                              cs_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk27m or posedge rst) begin
    if (rst) begin
      sclk <= 1'b1;
      cs   <= 1'b1;
      busy <= 1'b0;
    end else begin
      sclk <= sclk_d;
      cs   <= cs_d;
      busy <= busy_d;
    end
  end

  always_ff @(posedge clk27m or posedge rst) begin
    if (rst) begin
      cnt_q    <= 8'd0;
      bit_q    <= 3'd0;
      last_q   <= 1'b0;
      pend_q   <= 1'b0;
      tx_sh_q  <= 8'd0;
      rx_sh_q  <= 8'd0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      pend_q   <= (state_q == S_WAIT) && hs;

      if (enter)           cnt_q <= period(state_d);
      else if (!tc)        cnt_q <= cnt_q - 8'd1;

      if (hs) last_q <= tx_last;

      if (enter && (state_d == S_LOW)) begin
        mosi    <= tx_sh_q[7];
        tx_sh_q <= {tx_sh_q[6:0], 1'b0};
        bit_q   <= (state_q == S_HIGH) ? (bit_q - 3'd1) : 3'd7;
      end else if (hs) begin
        tx_sh_q <= tx_data;
      end

      if ((state_q == S_LAG) && (state_d == S_GAP)) mosi <= 1'b0;

      if ((state_q == S_HIGH) && tc) begin
        rx_sh_q <= {rx_sh_q[6:0], rx_bit};
        if (bit_q == 3'd0) begin
          rx_data  <= {rx_sh_q[6:0], rx_bit};
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with CLK_DIV=2; a mode-3 slave model returns a fixed byte.
module tb_spi_master;

  logic       clk27m = 1'b0;
  logic       rst    = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso = 1'b0;

  int vecs = 0;
  int errs = 0;

  int fall_cnt = 0, rise_cnt = 0, rxv_cnt = 0;
  int cs_lo_run = 0, cs_hi_run = 0, last_cs_lo = 0, last_cs_hi = 0;
  int hi_run = 0, gap_run = 0, gap_cyc = 0, gap_rdy = 0;
  logic [7:0] mosi_mon = 8'd0;
  logic [7:0] rx_seen = 8'd0;
  logic [7:0] slave_byte = 8'h3C;
  logic [7:0] sl_sh = 8'd0;
  bit slave_en = 1'b1;

  spi_master #(.CLK_DIV(2), .CS_LEAD(4), .CS_LAG(4), .CS_IDLE(8)) dut (
    .clk27m  (clk27m),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .sclk    (sclk),
    .cs      (cs),
    .mosi    (mosi),
    .miso    (miso)
  );

  always #5 clk27m = ~clk27m;

  // slave model: shifts out on sclk falls, MSB first, rotating so every byte returns slave_byte
  always @(negedge cs) sl_sh = slave_byte;
  always @(negedge sclk) begin
    if (!cs) begin
      fall_cnt++;
      miso  = slave_en ? sl_sh[7] : 1'b0;
      sl_sh = {sl_sh[6:0], sl_sh[7]};
    end
  end
  always @(posedge sclk) begin
    if (!cs) begin
      rise_cnt++;
      mosi_mon = {mosi_mon[6:0], mosi};
    end
  end

  always @(negedge clk27m) begin
    if (rx_valid) begin
      rxv_cnt++;
      rx_seen = rx_data;
    end
    if (!cs) begin
      if (cs_hi_run != 0) last_cs_hi = cs_hi_run;
      cs_hi_run = 0;
      cs_lo_run++;
      if (sclk) hi_run++;
      else begin
        if (hi_run != 0 && fall_cnt == 9) gap_run = hi_run;
        hi_run = 0;
      end
    end else begin
      if (cs_lo_run != 0) last_cs_lo = cs_lo_run;
      cs_lo_run = 0;
      cs_hi_run++;
      hi_run = 0;
    end
    if (cs && busy) begin
      gap_cyc++;
      if (tx_ready) gap_rdy++;
    end
  end

  task automatic push(input logic [7:0] d, input logic l, output bit ok);
    ok = 1'b0;
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready) begin ok = 1'b1; break; end
      @(negedge clk27m);
    end
    @(negedge clk27m);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!busy && cs) begin ok = 1'b1; break; end
      @(negedge clk27m);
    end
  endtask

  task automatic wait_cs_high(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (cs) begin ok = 1'b1; break; end
      @(negedge clk27m);
    end
    @(negedge clk27m);
  endtask

  task automatic clear_mon();
    fall_cnt = 0; rise_cnt = 0; rxv_cnt = 0; gap_run = 0; gap_cyc = 0; gap_rdy = 0;
    mosi_mon = 8'd0; rx_seen = 8'd0;
  endtask

  task automatic test_reset();
    bit ok;
    int bad;
    repeat (3) @(negedge clk27m);
    vecs++; if (sclk !== 1'b1) begin errs++; $display("FAIL rst_sclk got %b want 1", sclk); end
    vecs++; if (cs !== 1'b1) begin errs++; $display("FAIL rst_cs got %b want 1", cs); end
    vecs++; if (mosi !== 1'b0) begin errs++; $display("FAIL rst_mosi got %b want 0", mosi); end
    vecs++; if (rx_data !== 8'h00) begin errs++; $display("FAIL rst_rx_data got %h want 00", rx_data); end
    vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL rst_rx_valid got %b want 0", rx_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL rst_tx_ready got %b want 1", tx_ready); end
    rst = 1'b0;
    @(negedge clk27m);
    clear_mon();
    push(8'h5A, 1'b1, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL abort_handshake got %b want 1", ok); end
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rise_cnt == 3) begin ok = 1'b1; break; end
      @(negedge clk27m);
    end
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL abort_reach_bit4 got %b want 1", ok); end
    repeat (2) @(negedge clk27m);
    vecs++; if ({cs, sclk, mosi} !== 3'b001) begin errs++; $display("FAIL abort_pre_state cs/sclk/mosi got %b want 001", {cs, sclk, mosi}); end
    #2 rst = 1'b1;
    #1;
    vecs++; if ({cs, sclk, mosi, busy} !== 4'b1100) begin errs++; $display("FAIL abort_async cs/sclk/mosi/busy got %b want 1100", {cs, sclk, mosi, busy}); end
    repeat (3) @(negedge clk27m);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk27m);
      if (!cs) bad++;
    end
    vecs++; if (rxv_cnt !== 0) begin errs++; $display("FAIL abort_rx_valid got %0d pulses want 0", rxv_cnt); end
    vecs++; if (bad !== 0) begin errs++; $display("FAIL abort_cs_low got %0d cycles want 0", bad); end
    vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL abort_tx_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_single_byte();
    bit ok;
    wait_idle(ok);
    clear_mon(); slave_byte = 8'h3C; slave_en = 1'b1;
    push(8'hB5, 1'b1, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL single_handshake got %b want 1", ok); end
    wait_cs_high(ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL single_end got %b want 1", ok); end
    vecs++; if (mosi_mon !== 8'hB5) begin errs++; $display("FAIL single_mosi got %h want b5", mosi_mon); end
    vecs++; if (fall_cnt !== 8) begin errs++; $display("FAIL single_falls got %0d want 8", fall_cnt); end
    vecs++; if (rxv_cnt !== 1) begin errs++; $display("FAIL single_rx_valid got %0d want 1", rxv_cnt); end
    vecs++; if (rx_seen !== 8'h3C) begin errs++; $display("FAIL single_rx_data got %h want 3c", rx_seen); end
    vecs++; if (last_cs_lo !== 40) begin errs++; $display("FAIL single_cs_low got %0d want 40", last_cs_lo); end
  endtask

  task automatic test_two_byte();
    bit ok;
    wait_idle(ok);
    clear_mon(); slave_byte = 8'h3C;
    push(8'hB5, 1'b0, ok);
    push(8'h10, 1'b1, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL two_handshake got %b want 1", ok); end
    wait_cs_high(ok);
    vecs++; if (fall_cnt !== 16) begin errs++; $display("FAIL two_falls got %0d want 16", fall_cnt); end
    vecs++; if (rxv_cnt !== 2) begin errs++; $display("FAIL two_rx_valid got %0d want 2", rxv_cnt); end
    vecs++; if (mosi_mon !== 8'h10) begin errs++; $display("FAIL two_mosi2 got %h want 10", mosi_mon); end
    vecs++; if (gap_run !== 4) begin errs++; $display("FAIL two_sclk_gap got %0d want 4", gap_run); end
    vecs++; if (last_cs_lo !== 74) begin errs++; $display("FAIL two_cs_low got %0d want 74", last_cs_lo); end
  endtask

  task automatic test_stall();
    bit ok;
    int bad_cs, bad_sclk, bad_rdy, bad_busy;
    wait_idle(ok);
    clear_mon(); slave_byte = 8'h3C;
    push(8'hC3, 1'b0, ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rxv_cnt == 1) begin ok = 1'b1; break; end
      @(negedge clk27m);
    end
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL stall_first_byte got %b want 1", ok); end
    bad_cs = 0; bad_sclk = 0; bad_rdy = 0; bad_busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk27m);
      if (cs !== 1'b0) bad_cs++;
      if (sclk !== 1'b1) bad_sclk++;
      if (tx_ready !== 1'b1) bad_rdy++;
      if (busy !== 1'b1) bad_busy++;
    end
    vecs++; if (bad_cs !== 0) begin errs++; $display("FAIL stall_cs got %0d bad cycles want 0", bad_cs); end
    vecs++; if (bad_sclk !== 0) begin errs++; $display("FAIL stall_sclk got %0d bad cycles want 0", bad_sclk); end
    vecs++; if (bad_rdy !== 0) begin errs++; $display("FAIL stall_tx_ready got %0d bad cycles want 0", bad_rdy); end
    vecs++; if (bad_busy !== 0) begin errs++; $display("FAIL stall_busy got %0d bad cycles want 0", bad_busy); end
    push(8'h6E, 1'b1, ok);
    wait_cs_high(ok);
    vecs++; if (rxv_cnt !== 2) begin errs++; $display("FAIL stall_rx_valid got %0d want 2", rxv_cnt); end
    vecs++; if (mosi_mon !== 8'h6E) begin errs++; $display("FAIL stall_mosi2 got %h want 6e", mosi_mon); end
    vecs++; if (rx_seen !== 8'h3C) begin errs++; $display("FAIL stall_rx_data got %h want 3c", rx_seen); end
  endtask

  task automatic test_frame_spacing();
    bit ok;
    wait_idle(ok);
    clear_mon();
    push(8'h81, 1'b1, ok);
    push(8'h7E, 1'b1, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL space_handshake got %b want 1", ok); end
    wait_cs_high(ok);
    repeat (12) @(negedge clk27m);
    vecs++; if (last_cs_hi !== 9) begin errs++; $display("FAIL space_cs_high got %0d want 9", last_cs_hi); end
    vecs++; if (gap_cyc !== 16) begin errs++; $display("FAIL space_gap_cycles got %0d want 16", gap_cyc); end
    vecs++; if (gap_rdy !== 0) begin errs++; $display("FAIL space_gap_tx_ready got %0d want 0", gap_rdy); end
    vecs++; if (mosi_mon !== 8'h7E) begin errs++; $display("FAIL space_mosi2 got %h want 7e", mosi_mon); end
  endtask

  task automatic test_loopback();
    bit ok;
    logic [7:0] want;
`ifdef SPI_MASTER_LOOPBACK_EN
    want = 8'hA5;
`else
    want = 8'h00;
`endif
    wait_idle(ok);
    clear_mon(); slave_en = 1'b0; miso = 1'b0;
    push(8'hA5, 1'b1, ok);
    wait_cs_high(ok);
    vecs++; if (rxv_cnt !== 1) begin errs++; $display("FAIL loop_rx_valid got %0d want 1", rxv_cnt); end
    vecs++; if (rx_seen !== want) begin errs++; $display("FAIL loop_rx_data got %h want %h", rx_seen, want); end
    slave_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_byte();
    test_stall();
    test_frame_spacing();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
